// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, dmem wait freezes,
// branch flushes and memory timeout trap. Optional macro: HAZ_PERF_CNT_EN.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] id_instr,
    input  logic        id_valid,
    input  logic [15:0] ex_instr,
    input  logic        ex_valid,
    input  logic        ex_branch_taken,
    input  logic [15:0] mem_instr,
    input  logic        mem_valid,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_stall,
    output logic        idex_bubble,
    output logic        exmem_stall,
    output logic        memwb_bubble,
    output logic        mem_timeout_err,
    output logic [1:0]  ctrl_state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_lu_stalls,
    output logic [CNT_W-1:0] perf_mem_stalls,
    output logic [CNT_W-1:0] perf_flushes
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    function automatic logic [3:0] f_rs1(input logic [15:0] i);
        return (i[15:12] != 4'hE) ? i[11:8] : 4'h0;
    endfunction

    function automatic logic [3:0] f_rs2(input logic [15:0] i);
        if (i[15:12] < 4'd6)
            return i[7:4];
        return (i[15:13] == 3'b110) ? i[3:0] : 4'h0;
    endfunction

    function automatic logic [3:0] f_dest(input logic [15:0] i);
        return (i[15:13] != 3'b110) ? i[3:0] : 4'h0;
    endfunction

    state_t          state_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;

    logic [3:0] id_rs1;
    logic [3:0] id_rs2;
    logic [3:0] ex_dest;
    logic       ex_load;
    logic       mem_acc;
    logic       freeze;
    logic       flush;
    logic       lu_haz;
    logic       lu;
    logic       unused_ok;

    assign id_rs1  = f_rs1(id_instr);
    assign id_rs2  = f_rs2(id_instr);
    assign ex_dest = f_dest(ex_instr);
    assign ex_load = (ex_instr[15:12] == 4'hB);
    assign mem_acc = mem_valid &
                     ((mem_instr[15:12] == 4'hB) |
                      (mem_instr[15:12] == 4'hC));

    assign unused_ok = ^{ex_instr[11:4], mem_instr[11:0], (CNT_W > 0)};

    // Freeze while a data access is outstanding or after a timeout
    assign freeze = ((state_q == RUN) & mem_acc & ~dmem_ack) |
                    ((state_q == MEM_WAIT) & ~dmem_ack) |
                    (state_q == ERR);

    assign flush  = ex_valid & ex_branch_taken & ~freeze;

    assign lu_haz = ex_valid & ex_load & (ex_dest != 4'h0) & id_valid &
                    ((ex_dest == id_rs1) | (ex_dest == id_rs2));

    assign lu     = lu_haz & ~freeze & ~flush;

    assign dmem_req     = ((state_q == RUN) & mem_acc) |
                          (state_q == MEM_WAIT);
    assign pc_stall     = freeze | lu;
    assign ifid_stall   = freeze | lu;
    assign ifid_flush   = flush;
    assign idex_stall   = freeze;
    assign idex_bubble  = flush | lu;
    assign exmem_stall  = freeze;
    assign memwb_bubble = freeze;

    assign mem_timeout_err = err_q;
    assign ctrl_state      = state_q;

    // Memory handshake FSM with wait-state timeout and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    to_cnt_q <= '0;
                    if (mem_acc & ~dmem_ack)
                        state_q <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (dmem_ack) begin
                        state_q  <= RUN;
                        to_cnt_q <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                        if (to_cnt_q == TO_LAST) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    err_q <= 1'b1;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] perf_lu_q;
    logic [CNT_W-1:0] perf_mem_q;
    logic [CNT_W-1:0] perf_fl_q;
    logic             mem_frz;

    assign mem_frz = freeze & (state_q != ERR);

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_q  <= '0;
            perf_mem_q <= '0;
            perf_fl_q  <= '0;
        end else begin
            if (lu && (perf_lu_q != '1))
                perf_lu_q <= perf_lu_q + 1'b1;
            if (mem_frz && (perf_mem_q != '1))
                perf_mem_q <= perf_mem_q + 1'b1;
            if (flush && (perf_fl_q != '1))
                perf_fl_q <= perf_fl_q + 1'b1;
        end
    end

    assign perf_lu_stalls  = perf_lu_q;
    assign perf_mem_stalls = perf_mem_q;
    assign perf_flushes    = perf_fl_q;
`endif

endmodule
